// File: rtl/uart_pkg.sv
// Shared UART types and constants for the flex-uart transmit and receive paths.
package uart_pkg;

   typedef enum logic [1:0] {
      PARITY_NONE = 2'd0,
      PARITY_ODD  = 2'd1,
      PARITY_EVEN = 2'd2
   } parity_t;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_t;

   localparam int UART_DEFAULT_CLKS_PER_BIT = 868;

   // Words narrower than 9 bits are zero-extended, which leaves the XOR unchanged.
   function automatic logic calc_parity(input logic [8:0] data, input parity_t mode);
      return (^data) ^ (mode == PARITY_ODD);
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the terminal count.
module uart_baud_gen #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] count_q;

   assign tick = enable && (count_q == TERMINAL);

   // NOTE: sequential state is written with non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (enable) begin
         count_q <= tick ? '0 : count_q + 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready word intake, serialized as start, data LSB-first,
// optional parity and 1..2 stop bits, with a registered pad-ready tx output.
module uart_tx
   import uart_pkg::*;
#(
   parameter int      CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
   parameter int      DATA_BITS    = 8,
   parameter parity_t PARITY       = PARITY_NONE,
   parameter int      STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 busy
);

   if (CLKS_PER_BIT < 2) begin : g_bad_clks
      $error("uart_tx: CLKS_PER_BIT must be >= 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
      $error("uart_tx: DATA_BITS must be in 5..9");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx: STOP_BITS must be 1 or 2");
   end

   localparam logic [2:0] S_IDLE   = ST_IDLE;
   localparam logic [2:0] S_START  = ST_START;
   localparam logic [2:0] S_DATA   = ST_DATA;
   localparam logic [2:0] S_PARITY = ST_PARITY;
   localparam logic [2:0] S_STOP   = ST_STOP;

   localparam int BIT_W = $clog2(DATA_BITS + 1);
   localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

   logic [2:0]           state_q, state_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic                 par_q, par_d;
   logic                 tx_q, tx_d;
   logic                 tick, clear, handshake, last_stop;

   uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (clear),
      .enable (busy),
      .tick   (tick)
   );

   // Accepting in the last stop cycle lets the next start bit follow with no gap.
   assign last_stop = (state_q == S_STOP) && tick && (bit_cnt_q == LAST_STOP);
   assign tx_ready  = (state_q == S_IDLE) || last_stop;
   assign handshake = tx_valid && tx_ready;
   assign busy      = (state_q != S_IDLE);
   assign clear     = (state_d != state_q);
   assign tx        = tx_q;

   // NOTE: every variable gets a default first so no latch can be inferred.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      par_d     = par_q;
      case (state_q)
         S_IDLE: ;
         S_START: if (tick) state_d = S_DATA;
         S_DATA: begin
            if (tick) begin
               if (bit_cnt_q == LAST_DATA) begin
                  bit_cnt_d = '0;
                  state_d   = (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  shreg_d   = shreg_q >> 1;
               end
            end
         end
         S_PARITY: if (tick) state_d = S_STOP;
         S_STOP: begin
            if (tick) begin
               if (bit_cnt_q == LAST_STOP) begin
                  bit_cnt_d = '0;
                  state_d   = S_IDLE;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (handshake) begin
         state_d   = S_START;
         shreg_d   = tx_data;
         par_d     = calc_parity(9'(tx_data), PARITY);
         bit_cnt_d = '0;
      end
   end

   // tx is derived from the next state so the pad sees a clean registered level.
   always_comb begin
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shreg_d[0];
         S_PARITY: tx_d = par_d;
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         par_q     <= 1'b0;
         tx_q      <= 1'b1;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         par_q     <= par_d;
         tx_q      <= tx_d;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances cover 8N1, 8E1, 8O1 and 8N2 framing.
module tb_uart_tx;
   import uart_pkg::*;

   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] valid;
   logic [3:0] ready;
   logic [3:0] tx;
   logic [3:0] busy;
   logic [7:0] data [4];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PARITY_NONE), .STOP_BITS(1)) dut_8n1 (
      .clk(clk), .rst_n(rst_n), .tx_data(data[0]), .tx_valid(valid[0]),
      .tx_ready(ready[0]), .tx(tx[0]), .busy(busy[0]));
   uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PARITY_EVEN), .STOP_BITS(1)) dut_8e1 (
      .clk(clk), .rst_n(rst_n), .tx_data(data[1]), .tx_valid(valid[1]),
      .tx_ready(ready[1]), .tx(tx[1]), .busy(busy[1]));
   uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PARITY_ODD), .STOP_BITS(1)) dut_8o1 (
      .clk(clk), .rst_n(rst_n), .tx_data(data[2]), .tx_valid(valid[2]),
      .tx_ready(ready[2]), .tx(tx[2]), .busy(busy[2]));
   uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PARITY_NONE), .STOP_BITS(2)) dut_8n2 (
      .clk(clk), .rst_n(rst_n), .tx_data(data[3]), .tx_valid(valid[3]),
      .tx_ready(ready[3]), .tx(tx[3]), .busy(busy[3]));

   task automatic check(input string tag, input logic observed, input logic expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, observed, expected);
      end
   endtask

   // Entered at the negedge of handshake cycle N; checks every cycle N+1..N+F and
   // returns at the negedge of N+F. Frame bits are written start bit first.
   task automatic run_frame(input int d, input string tag, input string bits,
                            input logic keep_valid, input logic [7:0] next_data);
      int n = bits.len() * CPB;
      check({tag, " ready@N"}, ready[d], 1'b1);
      @(negedge clk);
      data[d] = next_data;
      if (!keep_valid) valid[d] = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (i != 0) @(negedge clk);
         check($sformatf("%s tx@N+%0d", tag, i + 1), tx[d], bits[i / CPB] == "1");
         check($sformatf("%s ready@N+%0d", tag, i + 1), ready[d], i == n - 1);
         check($sformatf("%s busy@N+%0d", tag, i + 1), busy[d], 1'b1);
      end
   endtask

   task automatic check_idle(input int d, input string tag);
      check({tag, " idle tx"}, tx[d], 1'b1);
      check({tag, " idle ready"}, ready[d], 1'b1);
      check({tag, " idle busy"}, busy[d], 1'b0);
   endtask

   initial begin
      rst_n = 1'b0;
      valid = 4'hF;
      for (int d = 0; d < 4; d++) data[d] = 8'hA5;

      // Reset held for 10 cycles with tx_valid high.
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         for (int d = 0; d < 4; d++) check($sformatf("reset tx d%0d c%0d", d, c), tx[d], 1'b1);
      end
      for (int d = 0; d < 4; d++) begin
         check($sformatf("reset ready d%0d", d), ready[d], 1'b1);
         check($sformatf("reset busy d%0d", d), busy[d], 1'b0);
      end
      valid = 4'h0;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_idle(0, "post-reset");

      // 8N1 0xA5; tx_data changes mid-frame must not leak into the frame.
      data[0] = 8'hA5; valid[0] = 1'b1;
      run_frame(0, "8N1 A5", "0101001011", 1'b0, 8'h00);
      @(negedge clk);
      check_idle(0, "8N1 A5 N+41");
      repeat (3) @(negedge clk);
      check(    "8N1 quiet tx", tx[0], 1'b1);

      // 8E1 and 8O1 with 0x07: parity 1 and 0 respectively.
      data[1] = 8'h07; valid[1] = 1'b1;
      run_frame(1, "8E1 07", "01110000011", 1'b0, 8'h07);
      @(negedge clk);
      check_idle(1, "8E1 07 N+45");
      data[2] = 8'h07; valid[2] = 1'b1;
      run_frame(2, "8O1 07", "01110000001", 1'b0, 8'h07);
      @(negedge clk);
      check_idle(2, "8O1 07 N+45");

      // Back-to-back 0x00 then 0xFF with tx_valid held high.
      data[0] = 8'h00; valid[0] = 1'b1;
      run_frame(0, "b2b 00", "0000000001", 1'b1, 8'hFF);
      run_frame(0, "b2b FF", "0111111111", 1'b0, 8'h00);
      @(negedge clk);
      check_idle(0, "b2b end");

      // 8N2 0x3C: ready only in the last of the eight stop cycles.
      data[3] = 8'h3C; valid[3] = 1'b1;
      run_frame(3, "8N2 3C", "00011110011", 1'b0, 8'h3C);
      @(negedge clk);
      check_idle(3, "8N2 3C N+45");

      // Asynchronous reset during data bit 3 (cycles N+17..N+20).
      data[0] = 8'h00; valid[0] = 1'b1;
      check("rst-mid ready@N", ready[0], 1'b1);
      @(negedge clk);
      valid[0] = 1'b0;
      repeat (17) @(negedge clk);
      check("rst-mid tx before", tx[0], 1'b0);
      check("rst-mid busy before", busy[0], 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("rst-mid tx async", tx[0], 1'b1);
      check("rst-mid busy async", busy[0], 1'b0);
      check("rst-mid ready async", ready[0], 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check($sformatf("rst-mid no resume tx c%0d", c), tx[0], 1'b1);
      end
      check_idle(0, "rst-mid after release");

      // Fresh word after the abandoned frame.
      data[0] = 8'h55; valid[0] = 1'b1;
      run_frame(0, "8N1 55", "0101010101", 1'b0, 8'h00);
      @(negedge clk);
      check_idle(0, "8N1 55 end");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
# uart_tx

Parameterized UART transmitter: accepts parallel words over a valid/ready handshake and serializes each one as start bit, data bits LSB-first, optional parity and 1 or 2 stop bits. Each bit lasts a fixed number of clock cycles. It is the transmit-side counterpart of the flex-uart receive path and shares that path's frame format and parameter set. The serial output is fully registered and can drive a pad directly.

## Interface
- CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200); must be ≥ 2
- DATA_BITS, 8, data bits per frame; legal range 5..9
- PARITY, PARITY_NONE, parity mode of type uart_pkg::parity_t (NONE/ODD/EVEN)
- STOP_BITS, 1, number of stop bits; 1 or 2
- Illegal parameter values cause an elaboration-time `$error`.
- clk  input  1  clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- tx_data  input  DATA_BITS  word to send; sampled only on handshake
- tx_valid  input  1  word available
- tx_ready  output  1  block can accept a word this cycle
- tx  output  1  serial line, idle high
- busy  output  1  a frame is in progress

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- **Reset values:** state = IDLE, tx = 1, tx_ready = 1, busy = 0, all counters = 0.
- **Handshake:** a word transfers in any cycle where tx_valid and tx_ready are both 1.
  - tx_data is latched into a shift register.
  - The parity bit is computed from tx_data in the same cycle (odd: ^data ^ 1; even: ^data).
  - A transfer always moves the FSM to START.
- **tx_ready:** 1 in IDLE, and also in the final cycle of the last stop bit. This allows gapless back-to-back frames. It is 0 otherwise.
- **busy:** 1 whenever state ≠ IDLE.
- **Baud counter:** width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1 and wraps.
  - Terminal count ends the current bit.
  - The counter is cleared on every state entry.
- **Bit counter:** width $clog2(DATA_BITS+1) for DATA; reused for the stop-bit count.
- **Transitions:**
  - START → DATA.
  - DATA → after DATA_BITS bits, go to PARITY if PARITY ≠ NONE, else STOP. The shift register shifts right one position per bit.
  - PARITY → STOP.
  - STOP → after STOP_BITS bits, go to IDLE. If a handshake occurs in the final stop cycle, go directly to START instead.
- **tx values per state:** START 0; DATA shreg[0]; PARITY parity bit; STOP 1; IDLE 1.
- **Boundary behaviour:**
  - Changes to tx_data or tx_valid outside a handshake cycle are ignored.
  - Dropping tx_valid before a handshake sends nothing.
  - rst_n asserted mid-frame: tx goes to 1 asynchronously and the frame is abandoned. No partial frame resumes after reset release.

## Timing
- Let N be the handshake cycle.
- The start bit drives tx = 0 in cycles N+1 .. N+CLKS_PER_BIT.
- Bit k of the frame (k = 0 is the start bit) occupies cycles N+1+k·CLKS_PER_BIT .. N+(k+1)·CLKS_PER_BIT.
- Frame length F = CLKS_PER_BIT·(1 + DATA_BITS + (PARITY≠NONE) + STOP_BITS) cycles.
- tx_ready is 0 in cycles N+1 .. N+F-1 and 1 in cycle N+F.
- Back-to-back frames: if the second handshake is in cycle N+F, its start bit begins in cycle N+F+1, with no extra idle cycle.
- If there is no handshake in cycle N+F, the FSM is in IDLE at N+F+1 and tx stays 1.
- Latency from handshake to the first tx edge is 1 cycle. tx is registered and glitch-free.

## Structure
- **uart_pkg:**
  - parity_t enum (PARITY_NONE, PARITY_ODD, PARITY_EVEN).
  - tx_state_t enum (IDLE, START, DATA, PARITY, STOP).
  - Shared constant UART_DEFAULT_CLKS_PER_BIT = 868.
  - The receiver imports the same package.
- **Sub-module uart_baud_gen:**
  - Parameterized by CLKS_PER_BIT.
  - Inputs: clear, enable. Output: a one-cycle tick on terminal count.
  - Instantiated once inside uart_tx.
- Everything else (FSM, shift register, bit counter, parity) lives in uart_tx.

## Test plan
All scenarios use CLKS_PER_BIT = 4 and DATA_BITS = 8 unless noted.
- **Reset:** assert rst_n = 0 → tx = 1, tx_ready = 1, busy = 0. Hold for 10 cycles with tx_valid = 1 → tx stays 1.
- **8N1, 0xA5, handshake at N:**
  - tx = 0,1,0,1,0,0,1,0,1,1, each value held 4 cycles, over N+1..N+40.
  - tx_ready is 0 over N+1..N+39 and 1 at N+40.
  - busy returns to 0 at N+41.
- **8E1 and 8O1, 0x07:**
  - Even parity: bit in cycles N+37..N+40 is 1; stop bit at N+41..N+44.
  - Odd parity: parity bit is 0.
- **Back-to-back 0x00 then 0xFF with tx_valid held high:**
  - Second handshake occurs at N+40.
  - Second start bit occupies N+41..N+44, with no idle-high gap.
- **8N2, 0x3C:** stop high for 8 cycles (N+37..N+44); tx_ready is 1 only at N+44.
- **Reset during data bit 3:**
  - tx = 1 within the same cycle (asynchronous).
  - After release: IDLE, tx_ready = 1.
  - Next word 0x55 transmits correctly starting from its own handshake.
